cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core.sv | 177 +++++++++++++++++
 tb/tb_cpu_core.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Five-step accumulator CPU: single-bus datapath, on-chip RAM with a
// synchronous read port, and a program-load port usable while in reset or halted.
module cpu_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step_en,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out_value,
   output logic              out_valid,
   output logic              halted,
   output logic [DATA_W-1:0] bus_dbg,
   output logic              carry_flag,
   output logic              zero_flag
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

   step_t             step, step_next;
   logic [ADDR_W-1:0] pc, mar, rd_addr;
   logic [DATA_W-1:0] a, b, ir, out_reg, ram_q, bus;
   logic              carry, zero;
   logic [DATA_W-1:0] ram [DEPTH];

   logic [3:0]        opcode;
   logic [DATA_W-1:0] opr_ext, pc_ext;
   logic [DATA_W:0]   alu_sum;
   logic              advance;
   logic load_mar, load_ir, inc_pc, load_pc, load_a, load_b, load_out;
   logic load_flags, core_we, halt_set;

   assign opcode  = ir[DATA_W-1 -: 4];
   assign opr_ext = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
   assign pc_ext  = {{(DATA_W-ADDR_W){1'b0}}, pc};
   assign advance = step_en && !halted && !rst;

   // Subtraction goes through the same adder as A + ~B + 1, so carry means "no borrow".
   always_comb begin
      if (opcode == OP_SUB)
         alu_sum = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
      else
         alu_sum = {1'b0, a} + {1'b0, b};
   end

   always_ff @(posedge clk) begin
      if (rst)
         step <= T0;
      else
         step <= step_next;
   end

   always_comb begin
      step_next = step;
      if (advance) begin
         case (step)
            T0:      step_next = T1;
            T1:      step_next = T2;
            T2:      step_next = T3;
            T3:      step_next = T4;
            default: step_next = T0;
         endcase
      end
   end

   // Control decode: exactly one bus source per step, selected by step and opcode.
   always_comb begin
      bus        = '0;
      load_mar   = 1'b0;
      load_ir    = 1'b0;
      inc_pc     = 1'b0;
      load_pc    = 1'b0;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_out   = 1'b0;
      load_flags = 1'b0;
      core_we    = 1'b0;
      halt_set   = 1'b0;
      if (!halted) begin
         case (step)
            T0: begin bus = pc_ext; load_mar = 1'b1; end
            T1: begin bus = ram_q; load_ir = 1'b1; inc_pc = 1'b1; end
            T2: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin bus = opr_ext; load_mar = 1'b1; end
                  OP_LDI: begin bus = opr_ext; load_a = 1'b1; end
                  OP_JMP: begin bus = opr_ext; load_pc = 1'b1; end
                  OP_JC:  if (carry) begin bus = opr_ext; load_pc = 1'b1; end
                  OP_JZ:  if (zero) begin bus = opr_ext; load_pc = 1'b1; end
                  OP_OUT: begin bus = a; load_out = 1'b1; end
                  OP_HLT: halt_set = 1'b1;
                  default: ;
               endcase
            end
            T3: begin
               case (opcode)
                  OP_LDA:         begin bus = ram_q; load_a = 1'b1; end
                  OP_ADD, OP_SUB: begin bus = ram_q; load_b = 1'b1; end
                  OP_STA:         begin bus = a; core_we = 1'b1; end
                  default: ;
               endcase
            end
            T4: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  bus        = alu_sum[DATA_W-1:0];
                  load_a     = 1'b1;
                  load_flags = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The RAM read address follows the MAR value being written, so data is ready one step later.
   assign rd_addr = load_mar ? bus[ADDR_W-1:0] : mar;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= '0;
         mar     <= '0;
         a       <= '0;
         b       <= '0;
         ir      <= '0;
         out_reg <= '0;
         ram_q   <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
         halted  <= 1'b0;
      end else if (advance) begin
         ram_q <= ram[rd_addr];
         if (load_mar)   mar     <= bus[ADDR_W-1:0];
         if (load_ir)    ir      <= bus;
         if (inc_pc)     pc      <= pc + ADDR_W'(1);
         if (load_pc)    pc      <= bus[ADDR_W-1:0];
         if (load_a)     a       <= bus;
         if (load_b)     b       <= bus;
         if (load_out)   out_reg <= bus;
         if (load_flags) begin
            carry <= alu_sum[DATA_W];
            zero  <= (alu_sum[DATA_W-1:0] == '0);
         end
         if (halt_set)   halted  <= 1'b1;
      end
   end

   // Core stores take priority; program loads are only honoured in reset or halt.
   always_ff @(posedge clk) begin
      if (core_we && advance)
         ram[mar] <= a;
      else if (prog_we && (rst || halted))
         ram[prog_addr] <= prog_data;
   end

   assign out_value  = out_reg;
   assign out_valid  = advance && load_out;
   assign bus_dbg    = bus;
   assign carry_flag = carry;
   assign zero_flag  = zero;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: table-driven ALU programs, hand-built
// corner sequences and random programs checked against an instruction-level model.
module tb_cpu_core;

   logic       clk = 1'b0;
   logic       rst, step_en, prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data, out_value, bus_dbg;
   logic       out_valid, halted, carry_flag, zero_flag;

   logic        rst_w, step_en_w, prog_we_w;
   logic [5:0]  prog_addr_w;
   logic [11:0] prog_data_w, out_value_w, bus_dbg_w;
   logic        out_valid_w, halted_w, carry_flag_w, zero_flag_w;

   int checks = 0;
   int failures = 0;
   int coincide_hits = 0;

   always #5 clk = ~clk;

   cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .step_en(step_en), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .out_value(out_value),
      .out_valid(out_valid), .halted(halted), .bus_dbg(bus_dbg),
      .carry_flag(carry_flag), .zero_flag(zero_flag)
   );

   cpu_core #(.DATA_W(12), .ADDR_W(6)) dut_w (
      .clk(clk), .rst(rst_w), .step_en(step_en_w), .prog_we(prog_we_w),
      .prog_addr(prog_addr_w), .prog_data(prog_data_w), .out_value(out_value_w),
      .out_valid(out_valid_w), .halted(halted_w), .bus_dbg(bus_dbg_w),
      .carry_flag(carry_flag_w), .zero_flag(zero_flag_w)
   );

   // A core store and an accepted program write must never land on the same edge.
   always @(posedge clk)
      if (dut.core_we && dut.advance && prog_we && (rst || halted))
         coincide_hits++;

   typedef struct {
      logic [7:0] a_val;
      logic [7:0] m_val;
      logic [3:0] op;
      logic [7:0] exp_a;
      logic       exp_c;
      logic       exp_z;
   } alu_vec_t;

   alu_vec_t   vecs [8];
   logic [7:0] img [16];

   // Instruction-level reference model state
   logic [7:0] m_mem [16];
   int m_pc, m_a, m_out;
   bit m_c, m_z, m_halt;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input bit en, output bit ov, output int bv);
      step_en = en;
      #1;
      ov = out_valid;
      bv = int'(bus_dbg);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [7:0] image [16]);
      rst = 1'b1;
      step_en = 1'b0;
      prog_we = 1'b1;
      for (int i = 0; i < 16; i++) begin
         prog_addr = 4'(i);
         prog_data = image[i];
         tick();
      end
      prog_we = 1'b0;
      tick();
   endtask

   task automatic run_cycles(input int n, output int pulses, output int first_at);
      bit ov;
      int bv;
      pulses = 0;
      first_at = -1;
      for (int i = 0; i < n; i++) begin
         cycle(1'b1, ov, bv);
         if (ov) begin
            if (pulses == 0) first_at = i;
            pulses++;
         end
      end
   endtask

   function automatic int model_step();
      logic [7:0] ins;
      logic [3:0] op, opr;
      int s, pulse;
      pulse = 0;
      ins = m_mem[m_pc];
      op = ins[7:4];
      opr = ins[3:0];
      m_pc = (m_pc + 1) % 16;
      case (op)
         4'h1: m_a = int'(m_mem[opr]);
         4'h2: begin
            s = m_a + int'(m_mem[opr]);
            m_c = (s > 255);
            m_a = s % 256;
            m_z = (m_a == 0);
         end
         4'h3: begin
            m_c = (m_a >= int'(m_mem[opr]));
            m_a = (m_a - int'(m_mem[opr]) + 256) % 256;
            m_z = (m_a == 0);
         end
         4'h4: m_mem[opr] = 8'(m_a);
         4'h5: m_a = int'(opr);
         4'h6: m_pc = int'(opr);
         4'h7: if (m_c) m_pc = int'(opr);
         4'h8: if (m_z) m_pc = int'(opr);
         4'hE: begin m_out = m_a; pulse = 1; end
         4'hF: m_halt = 1'b1;
         default: ;
      endcase
      return pulse;
   endfunction

   initial begin
      int pulses, first_at, mism, bv;
      bit ov;

      vecs[0] = '{8'd5,   8'd5,   4'h3, 8'd0,   1'b1, 1'b1};
      vecs[1] = '{8'd3,   8'd5,   4'h3, 8'd254, 1'b0, 1'b0};
      vecs[2] = '{8'd15,  8'd250, 4'h2, 8'd9,   1'b1, 1'b0};
      vecs[3] = '{8'd28,  8'd14,  4'h2, 8'd42,  1'b0, 1'b0};
      vecs[4] = '{8'd0,   8'd0,   4'h2, 8'd0,   1'b0, 1'b1};
      vecs[5] = '{8'd200, 8'd100, 4'h3, 8'd100, 1'b1, 1'b0};
      vecs[6] = '{8'd128, 8'd128, 4'h2, 8'd0,   1'b1, 1'b1};
      vecs[7] = '{8'd0,   8'd1,   4'h3, 8'd255, 1'b0, 1'b0};

      rst = 1'b1; step_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      rst_w = 1'b1; step_en_w = 1'b0; prog_we_w = 1'b0; prog_addr_w = '0; prog_data_w = '0;
      tick();

      // Reference program: 28 + 14 -> OUT -> HLT
      img = '{default: 8'h00};
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
      img[14] = 8'd28; img[15] = 8'd14;
      apply_stimulus(img);
      step_en = 1'b1;
      #1;
      check_output("rst_out_value", int'(out_value), 0);
      check_output("rst_out_valid", int'(out_valid), 0);
      check_output("rst_halted", int'(halted), 0);
      check_output("rst_carry", int'(carry_flag), 0);
      check_output("rst_zero", int'(zero_flag), 0);
      check_output("rst_bus_pc", int'(bus_dbg), 0);
      rst = 1'b0;
      run_cycles(20, pulses, first_at);
      check_output("ref_out_value", int'(out_value), 42);
      check_output("ref_pulses", pulses, 1);
      check_output("ref_pulse_cycle", first_at, 12);
      check_output("ref_halted", int'(halted), 1);

      // Halted core stays frozen whatever step_en does
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'(i % 2), ov, bv);
         if (ov) pulses++;
      end
      check_output("halt_no_pulse", pulses, 0);
      check_output("halt_out_value", int'(out_value), 42);
      check_output("halt_still", int'(halted), 1);
      check_output("halt_bus_idle", int'(bus_dbg), 0);

      // Table of ALU programs: LDA 14, <op> 15, OUT, HLT
      for (int v = 0; v < 8; v++) begin
         img = '{default: 8'h00};
         img[0] = 8'h1E; img[1] = {vecs[v].op, 4'hF}; img[2] = 8'hE0; img[3] = 8'hF0;
         img[14] = vecs[v].a_val; img[15] = vecs[v].m_val;
         apply_stimulus(img);
         rst = 1'b0;
         run_cycles(20, pulses, first_at);
         check_output($sformatf("vec%0d_a", v), int'(out_value), int'(vecs[v].exp_a));
         check_output($sformatf("vec%0d_carry", v), int'(carry_flag), int'(vecs[v].exp_c));
         check_output($sformatf("vec%0d_zero", v), int'(zero_flag), int'(vecs[v].exp_z));
         check_output($sformatf("vec%0d_halted", v), int'(halted), 1);
      end

      // LDI 15, ADD 14 (=250), OUT, JZ 0 (not taken), JC 0 (taken)
      img = '{default: 8'h00};
      img[0] = 8'h5F; img[1] = 8'h2E; img[2] = 8'hE0; img[3] = 8'h80; img[4] = 8'h70;
      img[14] = 8'd250;
      apply_stimulus(img);
      rst = 1'b0;
      run_cycles(15, pulses, first_at);
      check_output("ovf_a", int'(out_value), 9);
      check_output("ovf_carry", int'(carry_flag), 1);
      check_output("ovf_zero", int'(zero_flag), 0);
      run_cycles(5, pulses, first_at);
      check_output("jz_not_taken_pc", int'(bus_dbg), 4);
      run_cycles(5, pulses, first_at);
      check_output("jc_taken_pc", int'(bus_dbg), 0);

      // PC wrap over 16 NOPs, full speed then with step_en toggling
      img = '{default: 8'h00};
      for (int pass = 0; pass < 2; pass++) begin
         apply_stimulus(img);
         rst = 1'b0;
         mism = 0;
         for (int k = 0; k < 80; k++) begin
            if (pass == 1) begin
               cycle(1'b0, ov, bv);
               if (ov) mism++;
            end
            cycle(1'b1, ov, bv);
            if (bv != ((k % 5 == 0) ? (k / 5) % 16 : 0)) mism++;
         end
         check_output($sformatf("wrap_trace_pass%0d", pass), mism, 0);
         check_output($sformatf("wrap_pc_pass%0d", pass), int'(bus_dbg), 0);
      end

      // Reset at T3 of ADD, with ignored prog_we pulses while running
      img = '{default: 8'h00};
      img[0] = 8'h1E; img[1] = 8'hE0; img[2] = 8'h2F; img[3] = 8'hE0; img[4] = 8'hF0;
      img[14] = 8'd28; img[15] = 8'd14;
      apply_stimulus(img);
      rst = 1'b0;
      prog_we = 1'b1; prog_addr = 4'd15; prog_data = 8'd99;
      run_cycles(13, pulses, first_at);
      prog_we = 1'b0;
      check_output("mid_out_before", int'(out_value), 28);
      rst = 1'b1;
      tick();
      check_output("mid_rst_out_value", int'(out_value), 0);
      check_output("mid_rst_out_valid", int'(out_valid), 0);
      check_output("mid_rst_halted", int'(halted), 0);
      check_output("mid_rst_carry", int'(carry_flag), 0);
      check_output("mid_rst_bus", int'(bus_dbg), 0);
      rst = 1'b0;
      run_cycles(25, pulses, first_at);
      check_output("mid_rerun_out", int'(out_value), 42);
      check_output("mid_rerun_pulses", pulses, 2);
      check_output("mid_rerun_halted", int'(halted), 1);

      // Random programs against the instruction-level model, with random stalls
      for (int p = 0; p < 10; p++) begin
         for (int i = 0; i < 16; i++) begin
            img[i] = 8'($urandom);
            m_mem[i] = img[i];
         end
         m_pc = 0; m_a = 0; m_out = 0; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
         apply_stimulus(img);
         rst = 1'b0;
         for (int n = 0; n < 30 && !m_halt; n++) begin
            int exp_pulse;
            pulses = 0;
            for (int c = 0; c < 5; c++) begin
               for (int g = 0; g < 3 && $urandom_range(3) == 0; g++) begin
                  cycle(1'b0, ov, bv);
                  check_output("rnd_stall_valid", int'(ov), 0);
               end
               cycle(1'b1, ov, bv);
               if (ov) pulses++;
            end
            exp_pulse = model_step();
            check_output($sformatf("rnd%0d_i%0d_pulse", p, n), pulses, exp_pulse);
            check_output($sformatf("rnd%0d_i%0d_out", p, n), int'(out_value), m_out);
            check_output($sformatf("rnd%0d_i%0d_carry", p, n), int'(carry_flag), int'(m_c));
            check_output($sformatf("rnd%0d_i%0d_zero", p, n), int'(zero_flag), int'(m_z));
            check_output($sformatf("rnd%0d_i%0d_halted", p, n), int'(halted), int'(m_halt));
            if (!m_halt)
               check_output($sformatf("rnd%0d_i%0d_pc", p, n), int'(bus_dbg), m_pc);
         end
      end
      rst = 1'b1;
      tick();

      // Wide configuration: same program with operands 40/41
      prog_we_w = 1'b1;
      for (int i = 0; i < 64; i++) begin
         prog_addr_w = 6'(i);
         case (i)
            0:  prog_data_w = 12'h128;
            1:  prog_data_w = 12'h229;
            2:  prog_data_w = 12'hE00;
            3:  prog_data_w = 12'hF00;
            40: prog_data_w = 12'd28;
            41: prog_data_w = 12'd14;
            default: prog_data_w = 12'h000;
         endcase
         tick();
      end
      prog_we_w = 1'b0;
      tick();
      rst_w = 1'b0;
      step_en_w = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (out_valid_w) pulses++;
         tick();
      end
      check_output("wide_out_value", int'(out_value_w), 42);
      check_output("wide_pulses", pulses, 1);
      check_output("wide_halted", int'(halted_w), 1);
      check_output("wide_carry", int'(carry_flag_w), 0);

      check_output("core_write_priority", coincide_hits, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
